// File: rtl/csa_nibble_sequencer.sv
// rtl/csa_nibble_sequencer.sv - 16-bit add/subtract sequenced as four nibbles through an external 4-bit carry-select adder
// Optional feature macro: CSA_SEQ_SUB_EN (enables two's-complement subtraction via op_sub).
module csa_nibble_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_sub,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_out,
  output logic [3:0]  add_a,
  output logic [3:0]  add_b,
  output logic        add_cin,
  input  logic [3:0]  add_s,
  input  logic        add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        cr_q, cr_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;

  // Operand B and initial carry as captured at start; subtraction is A + ~B + 1.
  logic [15:0] b_load;
  logic        cr_load;

`ifdef CSA_SEQ_SUB_EN
  assign b_load  = op_sub ? ~b_in : b_in;
  assign cr_load = op_sub;
`else
  logic op_sub_unused;
  assign op_sub_unused = op_sub;
  assign b_load  = b_in;
  assign cr_load = 1'b0;
`endif

  // Current nibble of each latched operand, selected by the slice index.
  logic [3:0] a_slice, b_slice;
  logic [3:0] slice_lsb;

  assign slice_lsb = {idx_q, 2'b00};
  assign a_slice   = a_q[slice_lsb +: 4];
  assign b_slice   = b_q[slice_lsb +: 4];

  // Next-state and adder-drive logic; adder inputs are forced to zero outside RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cr_d     = cr_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_load;
          idx_d   = 2'd0;
          cr_d    = cr_load;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        add_a   = a_slice;
        add_b   = b_slice;
        add_cin = cr_q;
        result_d[slice_lsb +: 4] = add_s;
        cr_d    = add_cout;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          carry_d = add_cout;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset clears everything the outside world can see and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cr_q     <= 1'b0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      result_q <= 16'd0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cr_q     <= cr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_csa_nibble_sequencer.sv
// tb/tb_csa_nibble_sequencer.sv - directed self-checking bench for csa_nibble_sequencer
module tb_csa_nibble_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;

  int checks = 0;
  int errors = 0;

  csa_nibble_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout)
  );

  // Behavioural stand-in for the downstream 4-bit adder.
  logic [4:0] add_full;
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_s    = add_full[3:0];
  assign add_cout = add_full[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_adda"}, {28'd0, add_a}, 32'd0);
    chk({tag, "_addb"}, {28'd0, add_b}, 32'd0);
    chk({tag, "_cin"}, {31'd0, add_cin}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a_in   = 16'd0;
    b_in   = 16'd0;
    tick();
    tick();

    // Reset state
    chk_idle_outs("rst");
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);

    // Reset has priority over start
    start = 1'b1; a_in = 16'h1234; b_in = 16'h1111;
    tick();
    chk("rstprio_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rstprio_busy2", {31'd0, busy}, 32'd0);

    // 0x1234 + 0x4321, start in cycle 0
    start = 1'b1; a_in = 16'h1234; b_in = 16'h4321;
    tick();
    start = 1'b0;
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_done", {31'd0, done}, 32'd0);
    chk("c1_adda", {28'd0, add_a}, 32'h4);
    chk("c1_addb", {28'd0, add_b}, 32'h1);
    chk("c1_cin", {31'd0, add_cin}, 32'd0);
    tick();
    chk("c2_adda", {28'd0, add_a}, 32'h3);
    chk("c2_addb", {28'd0, add_b}, 32'h2);
    chk("c2_done", {31'd0, done}, 32'd0);
    tick();
    chk("c3_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("c4_busy", {31'd0, busy}, 32'd1);
    chk("c4_adda", {28'd0, add_a}, 32'h1);
    chk("c4_done", {31'd0, done}, 32'd0);
    tick();
    chk("c5_done", {31'd0, done}, 32'd1);
    chk("c5_busy", {31'd0, busy}, 32'd0);
    chk("c5_result", {16'd0, result}, 32'h5555);
    chk("c5_carry", {31'd0, carry_out}, 32'd0);
    chk("c5_adda", {28'd0, add_a}, 32'd0);
    tick();
    chk_idle_outs("c6");
    chk("c6_result_hold", {16'd0, result}, 32'h5555);

    // 0xFFFF + 0x0001: carry ripples through every slice
    start = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001;
    tick();
    start = 1'b0;
    chk("ff_cin1", {31'd0, add_cin}, 32'd0);
    tick();
    chk("ff_cin2", {31'd0, add_cin}, 32'd1);
    tick();
    chk("ff_cin3", {31'd0, add_cin}, 32'd1);
    tick();
    chk("ff_cin4", {31'd0, add_cin}, 32'd1);
    tick();
    chk("ff_done", {31'd0, done}, 32'd1);
    chk("ff_result", {16'd0, result}, 32'h0000);
    chk("ff_carry", {31'd0, carry_out}, 32'd1);
    tick();

    // start re-asserted while busy is ignored
    start = 1'b1; a_in = 16'h1111; b_in = 16'h2222;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a_in = 16'h0001; b_in = 16'h0001;
    tick();
    start = 1'b0;
    chk("ign_c3_done", {31'd0, done}, 32'd0);
    tick();
    chk("ign_c4_done", {31'd0, done}, 32'd0);
    tick();
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_result", {16'd0, result}, 32'h3333);
    tick();
    chk_idle_outs("ign_c6");
    tick();
    chk("ign_c7_done", {31'd0, done}, 32'd0);
    chk("ign_c7_result", {16'd0, result}, 32'h3333);

    // Reset mid-RUN aborts with no done
    start = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outs("abort");
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_carry", {31'd0, carry_out}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end

    // Operation after abort
    start = 1'b1; a_in = 16'h0F0F; b_in = 16'h0101;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("post_done", {31'd0, done}, 32'd1);
    chk("post_result", {16'd0, result}, 32'h1010);
    chk("post_carry", {31'd0, carry_out}, 32'd0);

    // start held in the DONE cycle: back-to-back without IDLE
    start = 1'b1; a_in = 16'h8000; b_in = 16'h8000;
    tick();
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done", {31'd0, done}, 32'd0);
    chk("b2b_result_hold", {16'd0, result}, 32'h1010);
    tick();
    tick();
    tick();
    chk("b2b_c4_done", {31'd0, done}, 32'd0);
    tick();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_result", {16'd0, result}, 32'h0000);
    chk("b2b_carry", {31'd0, carry_out}, 32'd1);
    tick();

    // op_sub: subtraction only when the feature is built in
    start = 1'b1; op_sub = 1'b1; a_in = 16'h0005; b_in = 16'h0007;
    tick();
    start = 1'b0; op_sub = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("sub_done", {31'd0, done}, 32'd1);
`ifdef CSA_SEQ_SUB_EN
    chk("sub_result", {16'd0, result}, 32'hFFFE);
`else
    chk("sub_result", {16'd0, result}, 32'h000C);
`endif
    chk("sub_carry", {31'd0, carry_out}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_nibble_sequencer.md
CSA_NIBBLE_SEQUENCER -- requirements
Module: csa_nibble_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to begin a 16-bit operation.
REQ-004 SHALL have port op_sub, input, 1, selects subtraction (used only per REQ-021).
REQ-005 SHALL have port a_in, input, 16, operand A, sampled with start.
REQ-006 SHALL have port b_in, input, 16, operand B, sampled with start.
REQ-007 SHALL have port busy, output, 1, high while slices are being issued.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port result, output, 16, registered sum/difference.
REQ-010 SHALL have port carry_out, output, 1, carry from the top slice.
REQ-011 SHALL have ports add_a (output, 4), add_b (output, 4) and add_cin (output, 1), slice operands and carry driven into the downstream 4-bit carry-select adder.
REQ-012 SHALL have ports add_s (input, 4) and add_cout (input, 1), combinational sum and carry returned by that adder in the same cycle.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, plus a 2-bit slice index idx and a carry register cr.
REQ-014 SHALL, in IDLE or DONE with start=1, latch a_in/b_in, clear idx, load cr per REQ-021 (0 for add), and enter RUN; otherwise IDLE stays IDLE and DONE goes to IDLE.
REQ-015 SHALL, in RUN, drive add_a=A[4*idx+3:4*idx], add_b=B slice (inverted per REQ-021) and add_cin=cr.
REQ-016 SHALL, on each RUN edge, write add_s into result[4*idx+3:4*idx], load cr<=add_cout and increment idx.
REQ-017 SHALL, on the RUN edge where idx=3, load carry_out<=add_cout and enter DONE.
REQ-018 SHALL give fixed latency: start high in cycle 0 gives RUN in cycles 1-4, done=1 in cycle 5 only.
REQ-019 SHALL hold busy=1 exactly in RUN, ignore start while busy, hold result/carry_out stable from DONE until the next RUN writes them, and drive add_a/add_b/add_cin=0 outside RUN.

Reset
REQ-020 SHALL, on rst=1 at an edge (including mid-RUN), force state IDLE, idx=0, cr=0, busy=0, done=0, result=0, carry_out=0; rst has priority over start, and an aborted operation produces no done.

Configuration
REQ-021 SHALL honour macro CSA_SEQ_SUB_EN: defined, start with op_sub=1 latches ~b_in and initial cr=1 (two's-complement subtract; carry_out=1 means no borrow); undefined, op_sub is ignored and every operation is addition with initial cr=0.

Verification
REQ-022 SHALL cover: a_in=0x1234, b_in=0x4321, start in cycle 0 -> done in cycle 5 only, result=0x5555, carry_out=0.
REQ-023 SHALL cover: 0xFFFF+0x0001 -> add_cin sequence 0,1,1,1 in cycles 1-4, result=0x0000, carry_out=1.
REQ-024 SHALL cover: start re-asserted with 0x0001/0x0001 in cycle 2 of an active 0x1111+0x2222 -> ignored, result=0x3333, one done pulse.
REQ-025 SHALL cover: rst=1 in cycle 2 of RUN -> all outputs 0 next cycle, no done; next operation 0x0F0F+0x0101 gives 0x1010.
REQ-026 SHALL cover: start held in the DONE cycle with new operands 0x8000+0x8000 -> RUN resumes with no IDLE cycle, second done 5 cycles later, result=0x0000, carry_out=1.
REQ-027 SHALL cover: 0x0005 op 0x0007 with op_sub=1 -> with CSA_SEQ_SUB_EN result=0xFFFE, carry_out=0; without it result=0x000C, carry_out=0.
